// File: rtl/position_stability_detector.sv
// Position stability detector: |sample - prev| against a runtime threshold, consecutive-stable count, lock flag.
// Optional macro STABILITY_HYSTERESIS_EN: in LOCKED, tolerate one unstable delta before unlocking.
module position_stability_detector #(
   parameter int unsigned WIDTH      = 10,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned COUNT_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   sample,
   input  logic               sample_valid,
   input  logic [WIDTH-1:0]   threshold,
   input  logic               clear,
   output logic [WIDTH-1:0]   delta,
   output logic               delta_valid,
   output logic [COUNT_W-1:0] stable_count,
   output logic               locked,
   output logic               lock_lost
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [COUNT_W-1:0] LC = COUNT_W'(LOCK_COUNT);

   state_t             state_q;
   logic [WIDTH-1:0]   prev_q;
   logic [WIDTH-1:0]   delta_q;
   logic               delta_valid_q;
   logic [COUNT_W-1:0] stable_count_q;
   logic               locked_q;
   logic               lock_lost_q;
`ifdef STABILITY_HYSTERESIS_EN
   logic               miss_q;
`endif

   logic [WIDTH-1:0]   delta_d;
   logic [COUNT_W-1:0] count_inc;
   logic               stable;
   logic               unlock;

   always_comb begin
      delta_d   = (sample > prev_q) ? (sample - prev_q) : (prev_q - sample);
      stable    = (delta_d <= threshold);
      count_inc = (stable_count_q == LC) ? LC : (stable_count_q + 1'b1);
`ifdef STABILITY_HYSTERESIS_EN
      unlock    = (state_q == LOCKED) && !stable && miss_q;
`else
      unlock    = (state_q == LOCKED) && !stable;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= EMPTY;
         prev_q         <= '0;
         delta_q        <= '0;
         delta_valid_q  <= 1'b0;
         stable_count_q <= '0;
         locked_q       <= 1'b0;
         lock_lost_q    <= 1'b0;
`ifdef STABILITY_HYSTERESIS_EN
         miss_q         <= 1'b0;
`endif
      end else begin
         delta_valid_q <= 1'b0;
         lock_lost_q   <= 1'b0;
         if (clear) begin
            // Sample arriving with clear is dropped, not used as a seed.
            state_q        <= EMPTY;
            delta_q        <= '0;
            stable_count_q <= '0;
            locked_q       <= 1'b0;
`ifdef STABILITY_HYSTERESIS_EN
            miss_q         <= 1'b0;
`endif
         end else if (sample_valid) begin
            prev_q <= sample;
            case (state_q)
               EMPTY: state_q <= TRACK;
               TRACK: begin
                  delta_q       <= delta_d;
                  delta_valid_q <= 1'b1;
                  if (stable) begin
                     stable_count_q <= count_inc;
                     if (count_inc == LC) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
`ifdef STABILITY_HYSTERESIS_EN
                        miss_q   <= 1'b0;
`endif
                     end
                  end else begin
                     stable_count_q <= '0;
                  end
               end
               LOCKED: begin
                  delta_q       <= delta_d;
                  delta_valid_q <= 1'b1;
                  if (stable) begin
                     stable_count_q <= count_inc;
`ifdef STABILITY_HYSTERESIS_EN
                     miss_q         <= 1'b0;
`endif
                  end else if (unlock) begin
                     state_q        <= TRACK;
                     locked_q       <= 1'b0;
                     lock_lost_q    <= 1'b1;
                     stable_count_q <= '0;
`ifdef STABILITY_HYSTERESIS_EN
                     miss_q         <= 1'b0;
                  end else begin
                     miss_q         <= 1'b1;
`endif
                  end
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign delta        = delta_q;
   assign delta_valid  = delta_valid_q;
   assign stable_count = stable_count_q;
   assign locked       = locked_q;
   assign lock_lost    = lock_lost_q;

endmodule

// File: tb/tb_position_stability_detector.sv
// Table-driven bench for position_stability_detector (LOCK_COUNT=4 main instance, LOCK_COUNT=1 side instance).
module tb_position_stability_detector;

`ifdef STABILITY_HYSTERESIS_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [9:0] sample;
   logic       sample_valid;
   logic [9:0] threshold;
   logic       clear;
   logic [9:0] delta;
   logic       delta_valid;
   logic [2:0] stable_count;
   logic       locked;
   logic       lock_lost;
   logic [9:0] delta1;
   logic       delta_valid1;
   logic [2:0] stable_count1;
   logic       locked1;
   logic       lock_lost1;

   int unsigned n_cmp;
   int unsigned n_bad;

   position_stability_detector #(.WIDTH(10), .LOCK_COUNT(4), .COUNT_W(3)) u_dut (
      .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
      .threshold(threshold), .clear(clear), .delta(delta), .delta_valid(delta_valid),
      .stable_count(stable_count), .locked(locked), .lock_lost(lock_lost)
   );

   position_stability_detector #(.WIDTH(10), .LOCK_COUNT(1), .COUNT_W(3)) u_dut1 (
      .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
      .threshold(threshold), .clear(clear), .delta(delta1), .delta_valid(delta_valid1),
      .stable_count(stable_count1), .locked(locked1), .lock_lost(lock_lost1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       vld;
      logic [9:0] smp;
      logic [9:0] thr;
      logic [9:0] e_delta;
      logic       e_dv;
      logic [2:0] e_cnt;
      logic       e_lk;
      logic       e_ll;
      logic       e_lk1;
   } vec_t;

   vec_t vecs[28];

   function automatic vec_t mk(input logic clr, input logic vld, input int smp, input int thr,
                               input int e_delta, input logic e_dv, input int e_cnt,
                               input logic e_lk, input logic e_ll, input logic e_lk1);
      vec_t v;
      v.clr = clr; v.vld = vld; v.smp = 10'(smp); v.thr = 10'(thr);
      v.e_delta = 10'(e_delta); v.e_dv = e_dv; v.e_cnt = 3'(e_cnt);
      v.e_lk = e_lk; v.e_ll = e_ll; v.e_lk1 = e_lk1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      //            clr vld smp   thr   delta dv  cnt lk           ll           lk1
      vecs[0]  = mk(0, 1, 100,  5,    0,    0,  0,  0,           0,           0);
      vecs[1]  = mk(0, 1, 103,  5,    3,    1,  1,  0,           0,           1);
      vecs[2]  = mk(0, 1, 98,   5,    5,    1,  2,  0,           0,           1);
      vecs[3]  = mk(0, 1, 100,  5,    2,    1,  3,  0,           0,           1);
      vecs[4]  = mk(0, 1, 101,  5,    1,    1,  4,  1,           0,           1);
      vecs[5]  = mk(0, 0, 0,    5,    1,    0,  4,  1,           0,           1);
      vecs[6]  = mk(0, 1, 101,  5,    0,    1,  4,  1,           0,           1);
      vecs[7]  = mk(0, 1, 200,  5,    99,   1,  HYST ? 4 : 0, HYST, !HYST, HYST);
      vecs[8]  = mk(0, 0, 0,    5,    99,   0,  HYST ? 4 : 0, HYST, 0,     HYST);
      vecs[9]  = mk(0, 1, 400,  5,    200,  1,  0,  0,           HYST,        0);
      vecs[10] = mk(0, 0, 0,    5,    200,  0,  0,  0,           0,           0);
      vecs[11] = mk(0, 1, 0,    1023, 400,  1,  1,  0,           0,           1);
      vecs[12] = mk(0, 1, 1023, 1023, 1023, 1,  2,  0,           0,           1);
      vecs[13] = mk(0, 1, 0,    1023, 1023, 1,  3,  0,           0,           1);
      vecs[14] = mk(0, 1, 1023, 0,    1023, 1,  0,  0,           0,           HYST);
      vecs[15] = mk(0, 1, 1023, 5,    0,    1,  1,  0,           0,           1);
      vecs[16] = mk(0, 1, 1023, 5,    0,    1,  2,  0,           0,           1);
      vecs[17] = mk(0, 1, 1023, 5,    0,    1,  3,  0,           0,           1);
      vecs[18] = mk(0, 1, 1020, 5,    3,    1,  4,  1,           0,           1);
      vecs[19] = mk(1, 1, 500,  5,    0,    0,  0,  0,           0,           0);
      vecs[20] = mk(0, 1, 7,    5,    0,    0,  0,  0,           0,           0);
      vecs[21] = mk(0, 1, 10,   5,    3,    1,  1,  0,           0,           1);
      vecs[22] = mk(1, 0, 0,    5,    0,    0,  0,  0,           0,           0);
      vecs[23] = mk(0, 1, 50,   5,    0,    0,  0,  0,           0,           0);
      vecs[24] = mk(0, 1, 53,   5,    3,    1,  1,  0,           0,           1);
      vecs[25] = mk(0, 1, 50,   5,    3,    1,  2,  0,           0,           1);
      vecs[26] = mk(0, 1, 53,   5,    3,    1,  3,  0,           0,           1);
      vecs[27] = mk(0, 1, 50,   5,    3,    1,  4,  1,           0,           1);

      reset = 1'b1; sample = '0; sample_valid = 1'b0; threshold = 10'd5; clear = 1'b0;
      #2;
      check("rst.delta", 32'(delta), 0);
      check("rst.dv", 32'(delta_valid), 0);
      check("rst.cnt", 32'(stable_count), 0);
      check("rst.locked", 32'(locked), 0);
      check("rst.lock_lost", 32'(lock_lost), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 28; i++) begin
         clear = vecs[i].clr; sample_valid = vecs[i].vld;
         sample = vecs[i].smp; threshold = vecs[i].thr;
         @(posedge clk);
         #1;
         check($sformatf("v%0d.delta", i), 32'(delta), 32'(vecs[i].e_delta));
         check($sformatf("v%0d.dv", i), 32'(delta_valid), 32'(vecs[i].e_dv));
         check($sformatf("v%0d.cnt", i), 32'(stable_count), 32'(vecs[i].e_cnt));
         check($sformatf("v%0d.locked", i), 32'(locked), 32'(vecs[i].e_lk));
         check($sformatf("v%0d.lock_lost", i), 32'(lock_lost), 32'(vecs[i].e_ll));
         check($sformatf("v%0d.locked_lc1", i), 32'(locked1), 32'(vecs[i].e_lk1));
      end

      // Async reset mid-cycle while locked with delta=3: outputs clear before any edge.
      sample_valid = 1'b0; clear = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("areset.locked", 32'(locked), 0);
      check("areset.delta", 32'(delta), 0);
      check("areset.cnt", 32'(stable_count), 0);
      check("areset.locked_lc1", 32'(locked1), 0);
      @(negedge clk);
      reset = 1'b0;
      sample = 10'd60; sample_valid = 1'b1; threshold = 10'd5;
      @(posedge clk);
      #1;
      check("post_rst_seed.dv", 32'(delta_valid), 0);
      check("post_rst_seed.delta", 32'(delta), 0);
      sample = 10'd62;
      @(posedge clk);
      #1;
      check("post_rst.delta", 32'(delta), 2);
      check("post_rst.dv", 32'(delta_valid), 1);
      check("post_rst.cnt", 32'(stable_count), 1);
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.dv_drop", 32'(delta_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/position_stability_detector.md
Name: position_stability_detector

Overview:
- Consumes a stream of 10-bit position samples (range bins or pixel coordinates) and forms the absolute difference between each sample and the previous one.
- Compares that delta against a runtime threshold and counts consecutive stable samples.
- Asserts a "locked" flag once the target has been stable for LOCK_COUNT samples.
- Sits downstream of the measurement/tracking front end; the tracking display and the control FSM consume its outputs.

Parameters:
- WIDTH, 10, sample/delta/threshold width in bits (unsigned).
- LOCK_COUNT, 4, consecutive stable deltas required to lock (1..2^COUNT_W-1).
- COUNT_W, 3, width of stable_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sample  in  WIDTH  new position sample, unsigned.
- sample_valid  in  1  one-cycle strobe; sample and threshold are valid this cycle.
- threshold  in  WIDTH  max delta still counted as stable (inclusive).
- clear  in  1  synchronous restart to EMPTY.
- delta  out  WIDTH  registered |sample - previous sample|.
- delta_valid  out  1  one-cycle pulse when delta updates.
- stable_count  out  COUNT_W  consecutive stable deltas, saturating at LOCK_COUNT.
- locked  out  1  level; high while in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->TRACK transition.

Behaviour:
- Reset (async, active-high): state=EMPTY; prev=0, delta=0, delta_valid=0, stable_count=0, locked=0, lock_lost=0. Outputs go to 0 without waiting for a clock edge.
- Arithmetic: delta_next = (sample > prev) ? sample-prev : prev-sample. Full WIDTH unsigned, so it never overflows (0 vs 1023 gives 1023). Stable condition is delta_next <= threshold, with threshold sampled in the sample_valid cycle.
- State EMPTY: on sample_valid, prev<=sample and go to TRACK. No delta_valid is generated and delta is unchanged.
- States TRACK and LOCKED: on sample_valid, prev<=sample, delta<=delta_next, and delta_valid=1 on the next cycle (latency 1 clock). In the same registered update:
  - If stable: stable_count <= min(stable_count+1, LOCK_COUNT). In TRACK, if the new count == LOCK_COUNT, go to LOCKED; locked rises in the same cycle as that delta_valid.
  - If not stable: stable_count<=0. If in LOCKED, go to TRACK, locked<=0, lock_lost=1 for one cycle (coincident with delta_valid).
- No sample_valid: all registers hold except delta_valid and lock_lost, which return to 0.
- clear: highest synchronous priority; overrides a simultaneous sample_valid, and that sample is discarded, not used as a seed. Result: state=EMPTY, delta=0, stable_count=0, locked=0, delta_valid=0, lock_lost=0. A clear never produces lock_lost.
- Back-to-back sample_valid on every cycle is supported at full rate, one delta per sample.
- LOCK_COUNT=1: the first stable delta locks.

Optional Feature:
- Macro: STABILITY_HYSTERESIS_EN.
- Defined: in LOCKED, a single unstable delta does not unlock. An internal miss flag is set, stable_count holds, locked stays 1, and no lock_lost is generated. A second consecutive unstable delta unlocks, with the normal lock_lost pulse and stable_count<=0. Any stable delta clears the miss flag. The miss flag is cleared by reset, by clear, and on entering LOCKED.
- Undefined: the first unstable delta in LOCKED unlocks, as described in Behaviour.

Test Plan:
- Seed: reset, then sample=100 with valid -> delta_valid stays 0, locked=0, stable_count=0.
- Lock: threshold=5, samples 100,103,98,100,101 -> deltas 3,5,2,1, each with a delta_valid pulse; stable_count 1,2,3,4; locked rises with the 4th delta_valid.
- Unlock (macro off): locked, then sample=200 -> delta=99, locked=0, lock_lost single pulse, stable_count=0. With the macro on, the same stimulus gives locked=1 and no lock_lost; a second sample=400 then gives delta=200, locked=0, lock_lost pulse.
- Extremes: samples 0 then 1023 -> delta=1023; then 0 -> delta=1023. Threshold=1023 -> both stable.
- Clear collision: clear=1 and sample_valid=1 with sample=500 in the same cycle while locked -> EMPTY, locked=0, no lock_lost. The next sample=7 only seeds, with no delta_valid.
- Async reset: assert reset between clock edges while locked with delta=3 -> locked, delta, stable_count read 0 before the next edge; the first sample after release only seeds.
